frame_sequencer: RTL and testbench
==================================

Name: frame_sequencer

Overview:
Controls the inbound image byte stream. Parses the 4-byte frame header (height, width), groups the following RGB bytes into 24-bit pixels, and tags each pixel with x/y coordinates and end-of-line/end-of-frame markers. Sits between the byte source (UART/SD/BRAM reader) and the pixel-processing/display pipeline. Sequences consecutive frames with valid/ready handshakes on both sides.

Parameters:
MAX_W, 640, largest legal width in pixels.
MAX_H, 480, largest legal height in pixels.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  byte on in_data is valid
in_data  in  8  header/RGB byte stream
in_ready  out  1  byte accepted when in_valid && in_ready
pix_valid  out  1  pixel output valid
pix_ready  in  1  downstream accepts pixel when pix_valid && pix_ready
pix_rgb  out  24  {R,G,B}; R is the first byte received
pix_x  out  16  column of current pixel, 0..width-1
pix_y  out  16  row of current pixel, 0..height-1
pix_eol  out  1  pixel is the last in its row
pix_eof  out  1  pixel is the last in the frame
height  out  16  latched frame height
width  out  16  latched frame width
hdr_valid  out  1  height/width valid for the current frame
err  out  1  sticky header error

Behaviour:
- Reset, asynchronous and immediate: state=HDR0; all outputs 0; byte index, x, y counters 0. Reset mid-frame aborts the frame. The first byte accepted after reset is height[7:0].
- States: HDR0, HDR1, HDR2, HDR3, PIX, DRAIN, ERR.
- Header is little-endian. HDR0 accepts height[7:0], HDR1 height[15:8], HDR2 width[7:0], HDR3 width[15:8]. in_ready=1 in all HDR states. Each state advances only on an accepted byte.
- On acceptance in HDR3:
  - If width==0, height==0, width>MAX_W or height>MAX_H: go to ERR, err=1.
  - Otherwise go to PIX, set hdr_valid=1, byte index=0, x=0, y=0.
- PIX: byte index 0/1/2 captures R/G/B. On accepting byte 2:
  - The pixel register loads {R,G,B}, x, y, eol=(x==width-1), eof=(eol && y==height-1).
  - pix_valid=1 on the next cycle. Latency is 1 cycle from the B byte to pix_valid.
  - x increments. On eol, x wraps to 0 and y increments.
  - If eof, go to DRAIN.
- In PIX, in_ready=0 only when byte index==2 and pix_valid && !pix_ready, so the output register never overflows. Full throughput when pix_ready=1.
- pix_valid stays high and pix_* stay stable until the handshake. After the handshake, pix_valid drops unless a new pixel is captured in the same cycle. In that case it stays high with the new data.
- DRAIN: in_ready=0. On the eof pixel handshake, clear hdr_valid and go to HDR0. The next frame's header cannot corrupt height/width while the eof pixel is pending.
- ERR: in_ready=1. Bytes are discarded so the upstream never stalls. pix_valid=0, hdr_valid=0, err held at 1 until reset.
- Arithmetic: x/y are 16-bit compares against the latched width/height. No wrap beyond width-1 or height-1 is possible.
- in_valid=0 in any state: no state change, counters hold.

Test Plan:
1. Bytes 02 00 03 00 then 18 RGB bytes, pix_ready=1, in_valid=1 continuously -> height=2, width=3, hdr_valid=1. Six pixels: (x,y) = (0,0),(1,0),(2,0),(0,1),(1,1),(2,1). eol on x=2; eof only on (2,1). hdr_valid=0 and state=HDR0 after the final handshake. pix_rgb of the first pixel equals bytes 4,5,6 as {R,G,B}.
2. Same frame, pix_ready=0 for 5 cycles after the 2nd pixel -> in_ready drops while the 3rd pixel's B byte is pending. pix_rgb/pix_x stay stable. No byte lost or duplicated; all six pixels match the input.
3. 1x1 frame (01 00 01 00 AA BB CC) immediately followed by header 02 00 02 00, with pix_ready held 0 for 3 cycles -> pix_eol=pix_eof=1 and rgb=AABBCC. in_ready=0 until the handshake. The second header then latches height=2, width=2.
4. Header 05 00 00 00 (width=0) -> err=1, state ERR. Later bytes are accepted (in_ready=1) with pix_valid=0. err stays 1 until reset.
5. Header E1 01 80 02 (height=481 > MAX_H) -> err=1. Header E0 01 80 02 (480x640) -> no error, hdr_valid=1.
6. Assert reset after header plus 2 pixel bytes -> outputs 0 immediately, asynchronously. After release, bytes 01 00 01 00 parse as a fresh 1x1 header.

Source files
------------

// File: rtl/frame_sequencer.sv
// Inbound image byte-stream sequencer: parses a 4-byte little-endian header (height, width),
// packs RGB bytes into tagged 24-bit pixels and handshakes frames back to back.
module frame_sequencer #(
    parameter int unsigned MAX_W = 640,
    parameter int unsigned MAX_H = 480
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_in_valid,
    input  logic [7:0]  i_in_data,
    output logic        o_in_ready,
    output logic        o_pix_valid,
    input  logic        i_pix_ready,
    output logic [23:0] o_pix_rgb,
    output logic [15:0] o_pix_x,
    output logic [15:0] o_pix_y,
    output logic        o_pix_eol,
    output logic        o_pix_eof,
    output logic [15:0] o_height,
    output logic [15:0] o_width,
    output logic        o_hdr_valid,
    output logic        o_err
);

    localparam logic [15:0] LP_MAX_W = 16'(MAX_W);
    localparam logic [15:0] LP_MAX_H = 16'(MAX_H);

    typedef enum logic [2:0] {
        StHdr0,
        StHdr1,
        StHdr2,
        StHdr3,
        StPix,
        StDrain,
        StErr
    } state_e;

    state_e      r_state;
    logic [15:0] r_height;
    logic [15:0] r_width;
    logic        r_hdr_valid;
    logic        r_err;
    logic [1:0]  r_idx;
    logic [15:0] r_x;
    logic [15:0] r_y;
    logic [7:0]  r_red;
    logic [7:0]  r_grn;
    logic        r_pix_valid;
    logic [23:0] r_pix_rgb;
    logic [15:0] r_pix_x;
    logic [15:0] r_pix_y;
    logic        r_pix_eol;
    logic        r_pix_eof;

    logic        w_in_ready;
    logic        w_accept;
    logic        w_pix_hs;
    logic [15:0] w_width_full;
    logic        w_hdr_bad;
    logic        w_eol;
    logic        w_eof;

    assign w_width_full = {i_in_data, r_width[7:0]};
    assign w_hdr_bad    = (w_width_full == 16'd0) || (r_height == 16'd0) ||
                          (w_width_full > LP_MAX_W) || (r_height > LP_MAX_H);
    assign w_eol        = (r_x == r_width - 16'd1);
    assign w_eof        = w_eol && (r_y == r_height - 16'd1);
    assign w_pix_hs     = r_pix_valid && i_pix_ready;
    assign w_accept     = i_in_valid && w_in_ready;

    // Hold off the B byte only while the output register is occupied and not draining.
    always_comb begin
        w_in_ready = 1'b0;
        if (!i_reset) begin
            case (r_state)
                StHdr0, StHdr1, StHdr2, StHdr3, StErr: w_in_ready = 1'b1;
                StPix:   w_in_ready = !((r_idx == 2'd2) && r_pix_valid && !i_pix_ready);
                default: w_in_ready = 1'b0;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= StHdr0;
            r_height    <= '0;
            r_width     <= '0;
            r_hdr_valid <= 1'b0;
            r_err       <= 1'b0;
            r_idx       <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_red       <= '0;
            r_grn       <= '0;
            r_pix_valid <= 1'b0;
            r_pix_rgb   <= '0;
            r_pix_x     <= '0;
            r_pix_y     <= '0;
            r_pix_eol   <= 1'b0;
            r_pix_eof   <= 1'b0;
        end else begin
            if (w_pix_hs) r_pix_valid <= 1'b0;
            case (r_state)
                StHdr0: if (w_accept) begin
                    r_height[7:0] <= i_in_data;
                    r_state       <= StHdr1;
                end
                StHdr1: if (w_accept) begin
                    r_height[15:8] <= i_in_data;
                    r_state        <= StHdr2;
                end
                StHdr2: if (w_accept) begin
                    r_width[7:0] <= i_in_data;
                    r_state      <= StHdr3;
                end
                StHdr3: if (w_accept) begin
                    r_width[15:8] <= i_in_data;
                    if (w_hdr_bad) begin
                        r_err   <= 1'b1;
                        r_state <= StErr;
                    end else begin
                        r_hdr_valid <= 1'b1;
                        r_idx       <= '0;
                        r_x         <= '0;
                        r_y         <= '0;
                        r_state     <= StPix;
                    end
                end
                StPix: if (w_accept) begin
                    case (r_idx)
                        2'd0: begin
                            r_red <= i_in_data;
                            r_idx <= 2'd1;
                        end
                        2'd1: begin
                            r_grn <= i_in_data;
                            r_idx <= 2'd2;
                        end
                        default: begin
                            r_idx       <= 2'd0;
                            r_pix_valid <= 1'b1;
                            r_pix_rgb   <= {r_red, r_grn, i_in_data};
                            r_pix_x     <= r_x;
                            r_pix_y     <= r_y;
                            r_pix_eol   <= w_eol;
                            r_pix_eof   <= w_eof;
                            if (w_eol) begin
                                r_x <= '0;
                                r_y <= r_y + 16'd1;
                            end else begin
                                r_x <= r_x + 16'd1;
                            end
                            if (w_eof) r_state <= StDrain;
                        end
                    endcase
                end
                // Only the eof pixel can be pending here.
                StDrain: if (w_pix_hs) begin
                    r_hdr_valid <= 1'b0;
                    r_state     <= StHdr0;
                end
                default: r_state <= StErr;
            endcase
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_pix_valid = r_pix_valid;
    assign o_pix_rgb   = r_pix_rgb;
    assign o_pix_x     = r_pix_x;
    assign o_pix_y     = r_pix_y;
    assign o_pix_eol   = r_pix_eol;
    assign o_pix_eof   = r_pix_eof;
    assign o_height    = r_height;
    assign o_width     = r_width;
    assign o_hdr_valid = r_hdr_valid;
    assign o_err       = r_err;

endmodule

// File: tb/tb_frame_sequencer.sv
// Randomized bench for frame_sequencer: streams frames and checks every cycle against a
// pixel list derived from the frame geometry and the byte stream.
module tb_frame_sequencer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        pix_valid;
    logic        pix_ready;
    logic [23:0] pix_rgb;
    logic [15:0] pix_x;
    logic [15:0] pix_y;
    logic        pix_eol;
    logic        pix_eof;
    logic [15:0] height;
    logic [15:0] width;
    logic        hdr_valid;
    logic        err;

    frame_sequencer #(
        .MAX_W(640),
        .MAX_H(480)
    ) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_in_valid (in_valid),
        .i_in_data  (in_data),
        .o_in_ready (in_ready),
        .o_pix_valid(pix_valid),
        .i_pix_ready(pix_ready),
        .o_pix_rgb  (pix_rgb),
        .o_pix_x    (pix_x),
        .o_pix_y    (pix_y),
        .o_pix_eol  (pix_eol),
        .o_pix_eof  (pix_eof),
        .o_height   (height),
        .o_width    (width),
        .o_hdr_valid(hdr_valid),
        .o_err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] rgb;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] h;
        logic [15:0] w;
        logic        eol;
        logic        eof;
    } pix_t;

    pix_t       exp_q[$];
    logic [7:0] bytes_q[$];
    int         frm_len[$];
    int         n_err;
    int         n_chk;

    logic [93:0] all_out;
    assign all_out = {in_ready, pix_valid, pix_rgb, pix_x, pix_y, pix_eol, pix_eof,
                      height, width, hdr_valid, err};

    task automatic do_reset();
        in_valid  = 1'b0;
        pix_ready = 1'b0;
        in_data   = 8'h00;
        reset     = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Reference: pixel k of an h x w frame sits at (k % w, k / w), fed by bytes 3k..3k+2.
    task automatic add_frame(input int h, input int w);
        pix_t p;
        logic [7:0] r, g, b;
        bytes_q.push_back(8'(h));
        bytes_q.push_back(8'(h >> 8));
        bytes_q.push_back(8'(w));
        bytes_q.push_back(8'(w >> 8));
        for (int k = 0; k < h * w; k++) begin
            r = 8'($urandom);
            g = 8'($urandom);
            b = 8'($urandom);
            bytes_q.push_back(r);
            bytes_q.push_back(g);
            bytes_q.push_back(b);
            p.rgb = {r, g, b};
            p.x   = 16'(k % w);
            p.y   = 16'(k / w);
            p.h   = 16'(h);
            p.w   = 16'(w);
            p.eol = ((k % w) == w - 1);
            p.eof = (k == h * w - 1);
            exp_q.push_back(p);
        end
        frm_len.push_back(4 + 3 * h * w);
    endtask

    task automatic run_stream(input string name, input int v_pct, input int r_pct,
                              input int stall_idx, input int stall_len, output int low_rdy);
        int   pos, f, o, hs_n, cap, cyc, stall_used, pending, total;
        logic exp_rdy;
        pix_t e;
        pos = 0; f = 0; o = 0; hs_n = 0; cap = 0; cyc = 0; stall_used = 0; low_rdy = 0;
        total = exp_q.size();
        while (hs_n < total && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            in_valid  = (pos < bytes_q.size()) && ($urandom_range(99) < v_pct);
            in_data   = in_valid ? bytes_q[pos] : 8'($urandom);
            pix_ready = ($urandom_range(99) < r_pct);
            if (hs_n == stall_idx && pix_valid && stall_used < stall_len) begin
                pix_ready = 1'b0;
                stall_used++;
            end
            #1;
            pending = cap - hs_n;
            if (pending > 0 && exp_q[hs_n].eof) exp_rdy = 1'b0;
            else if (o < 4) exp_rdy = 1'b1;
            else exp_rdy = !(((o - 4) % 3 == 2) && pending > 0 && !pix_ready);
            n_chk++;
            if (in_ready !== exp_rdy) begin
                n_err++;
                $display("FAIL %s in_ready cyc %0d: got %b want %b", name, cyc, in_ready, exp_rdy);
            end
            n_chk++;
            if (pix_valid !== (pending > 0)) begin
                n_err++;
                $display("FAIL %s pix_valid cyc %0d: got %b want %b", name, cyc, pix_valid,
                         pending > 0);
            end
            if (pending > 0) begin
                e = exp_q[hs_n];
                n_chk++;
                if ({pix_rgb, pix_x, pix_y, pix_eol, pix_eof} !== {e.rgb, e.x, e.y, e.eol, e.eof}) begin
                    n_err++;
                    $display("FAIL %s pixel %0d: got rgb=%h x=%0d y=%0d eol=%b eof=%b, want rgb=%h x=%0d y=%0d eol=%b eof=%b",
                             name, hs_n, pix_rgb, pix_x, pix_y, pix_eol, pix_eof,
                             e.rgb, e.x, e.y, e.eol, e.eof);
                end
                n_chk++;
                if ({height, width, hdr_valid, err} !== {e.h, e.w, 1'b1, 1'b0}) begin
                    n_err++;
                    $display("FAIL %s dims pixel %0d: got h=%0d w=%0d hv=%b err=%b, want h=%0d w=%0d hv=1 err=0",
                             name, hs_n, height, width, hdr_valid, err, e.h, e.w);
                end
            end
            if (!in_ready) low_rdy++;
            if (pix_valid && pix_ready) hs_n++;
            if (in_valid && in_ready) begin
                if (o >= 4 && (o - 4) % 3 == 2) cap++;
                pos++;
                o++;
                if (o == frm_len[f]) begin
                    f++;
                    o = 0;
                end
            end
        end
        n_chk++;
        if (hs_n < total) begin
            n_err++;
            $display("FAIL %s timeout: got %0d pixels want %0d", name, hs_n, total);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        pix_ready = 1'b0;
        #1;
        n_chk++;
        if ({hdr_valid, pix_valid, in_ready} !== 3'b001) begin
            n_err++;
            $display("FAIL %s idle after frame: got hv=%b pv=%b rdy=%b want hv=0 pv=0 rdy=1",
                     name, hdr_valid, pix_valid, in_ready);
        end
        bytes_q.delete();
        exp_q.delete();
        frm_len.delete();
    endtask

    task automatic test_reset();
        int low;
        reset = 1'b1;
        in_valid = 1'b0;
        pix_ready = 1'b0;
        in_data = 8'h00;
        #1;
        n_chk++;
        if (all_out !== 94'd0) begin
            n_err++;
            $display("FAIL reset_state: got %h want 0", all_out);
        end
        @(negedge clk);
        reset = 1'b0;
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        n_chk++;
        if ({pix_valid, hdr_valid, pix_rgb} !== {1'b1, 1'b1, 24'h123456}) begin
            n_err++;
            $display("FAIL reset_pre: got pv=%b hv=%b rgb=%h want pv=1 hv=1 rgb=123456",
                     pix_valid, hdr_valid, pix_rgb);
        end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_chk++;
        if (all_out !== 94'd0) begin
            n_err++;
            $display("FAIL reset_async: got %h want 0", all_out);
        end
        @(negedge clk);
        reset = 1'b0;
        add_frame(1, 1);
        run_stream("reset_fresh", 100, 100, -1, 0, low);
    endtask

    task automatic test_basic();
        int low;
        do_reset();
        add_frame(2, 3);
        run_stream("basic", 100, 100, -1, 0, low);
    endtask

    task automatic test_stall();
        int low;
        do_reset();
        add_frame(2, 3);
        run_stream("stall", 100, 100, 2, 5, low);
        n_chk++;
        if (low < 4) begin
            n_err++;
            $display("FAIL stall in_ready low cycles: got %0d want >=4", low);
        end
    endtask

    task automatic test_back_to_back();
        int low;
        do_reset();
        add_frame(1, 1);
        add_frame(2, 2);
        run_stream("b2b", 100, 100, 0, 3, low);
        n_chk++;
        if (low < 3) begin
            n_err++;
            $display("FAIL b2b drain in_ready low cycles: got %0d want >=3", low);
        end
    endtask

    task automatic test_random();
        int low;
        do_reset();
        for (int i = 0; i < 4; i++) add_frame($urandom_range(1, 5), $urandom_range(1, 6));
        run_stream("random", 70, 60, -1, 0, low);
    endtask

    task automatic test_err_width();
        do_reset();
        send_byte(8'h05); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        n_chk++;
        if ({err, hdr_valid, pix_valid} !== 3'b100) begin
            n_err++;
            $display("FAIL err_width: got err=%b hv=%b pv=%b want err=1 hv=0 pv=0",
                     err, hdr_valid, pix_valid);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_data   = 8'($urandom);
            pix_ready = 1'($urandom);
            #1;
            n_chk++;
            if ({in_ready, err, hdr_valid, pix_valid} !== 4'b1100) begin
                n_err++;
                $display("FAIL err_discard %0d: got rdy=%b err=%b hv=%b pv=%b want 1 1 0 0",
                         i, in_ready, err, hdr_valid, pix_valid);
            end
        end
        do_reset();
        #1;
        n_chk++;
        if (err !== 1'b0) begin
            n_err++;
            $display("FAIL err_cleared: got %b want 0", err);
        end
    endtask

    task automatic test_limits();
        do_reset();
        send_byte(8'hE1); send_byte(8'h01); send_byte(8'h80); send_byte(8'h02);
        n_chk++;
        if ({err, hdr_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL limit_h481: got err=%b hv=%b want err=1 hv=0", err, hdr_valid);
        end
        do_reset();
        send_byte(8'hE0); send_byte(8'h01); send_byte(8'h80); send_byte(8'h02);
        n_chk++;
        if ({err, hdr_valid, height, width, in_ready} !== {2'b01, 16'd480, 16'd640, 1'b1}) begin
            n_err++;
            $display("FAIL limit_max: got err=%b hv=%b h=%0d w=%0d rdy=%b want 0 1 480 640 1",
                     err, hdr_valid, height, width, in_ready);
        end
        pix_ready = 1'b1;
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        n_chk++;
        if ({pix_valid, pix_rgb, pix_x, pix_y, pix_eol, pix_eof} !==
            {1'b1, 24'h112233, 16'd0, 16'd0, 2'b00}) begin
            n_err++;
            $display("FAIL limit_pixel: got pv=%b rgb=%h x=%0d y=%0d eol=%b eof=%b want 1 112233 0 0 0 0",
                     pix_valid, pix_rgb, pix_x, pix_y, pix_eol, pix_eof);
        end
        do_reset();
    endtask

    initial begin
        n_err = 0;
        n_chk = 0;
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_random();
        test_err_width();
        test_limits();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
